// File: rtl/v_issue_seq_pkg.sv
// v_issue_seq_pkg: shared vector types, decode constants and element-size lookup
package v_issue_seq_pkg;
  localparam int VLEN = 512;
  localparam int DATA_W = 64;
  localparam int VL_W = 7;
  localparam int BEAT_W = 3;
  typedef enum logic [1:0] {UNIT_ALU, UNIT_RED, UNIT_SLDU, UNIT_LSU} unit_e;
  typedef enum logic {IDLE, ISSUE} state_e;
  typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW64} vsew_e;
  typedef enum logic [6:0] {
    OP_LOAD_FP  = 7'b0000111,
    OP_STORE_FP = 7'b0100111,
    OP_V        = 7'b1010111
  } opcode_e;
  typedef enum logic [2:0] {
    OPI_VV, OPF_VV, OPM_VV, OPI_VI, OPI_VX, OPF_VF, OPM_VX, OPC_CFG
  } funct3_e;
  typedef enum logic [5:0] {
    F6_VADD   = 6'b000000, F6_VSUB  = 6'b000010, F6_VMIN  = 6'b000101,
    F6_VMAX   = 6'b000111, F6_VAND  = 6'b001001, F6_VOR   = 6'b001010,
    F6_VXOR   = 6'b001011, F6_VSLL  = 6'b100101, F6_VSRL  = 6'b101000,
    F6_VSRA   = 6'b101001, F6_VMERGE = 6'b010111, F6_VMSEQ = 6'b011000,
    F6_VMSNE  = 6'b011001, F6_VMSLT = 6'b011011, F6_VMSLE = 6'b011101,
    F6_VMSGT  = 6'b011111
  } funct6_alu_e;
  typedef enum logic [5:0] {F6_VREDSUM = 6'b000000, F6_VREDMAX = 6'b000111} funct6_red_e;
  typedef enum logic [5:0] {
    F6_VSLIDEUP = 6'b001110, F6_VSLIDEDOWN = 6'b001111,
    F6_VSLIDE_X2E = 6'b101110, F6_VSLIDE_X2F = 6'b101111
  } funct6_sldu_e;
  function automatic logic [2:0] esz(input logic [1:0] vsew);
    return vsew == SEW8 ? 3'd1 : vsew == SEW16 ? 3'd2 : vsew == SEW32 ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/v_issue_decode.sv
// v_issue_decode: combinational legality check and execution-unit classification
module v_issue_decode
  import v_issue_seq_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [5:0] funct6_i,
  input  logic [1:0] vsew_i,
  output logic       legal_o,
  output unit_e      unit_o
);
  logic w_ls, w_v, w_red, w_sldu, w_alu;
  always_comb begin
    w_ls   = opcode_i inside {OP_LOAD_FP, OP_STORE_FP};
    w_v    = opcode_i == OP_V;
    w_red  = w_v && funct3_i == OPM_VV && funct6_i inside {F6_VREDSUM, F6_VREDMAX};
    w_sldu = w_v && funct3_i inside {OPI_VX, OPI_VI, OPM_VX} &&
             funct6_i inside {F6_VSLIDEUP, F6_VSLIDEDOWN, F6_VSLIDE_X2E, F6_VSLIDE_X2F};
    w_alu  = w_v && funct3_i inside {OPI_VV, OPI_VX, OPI_VI} &&
             funct6_i inside {F6_VADD, F6_VSUB, F6_VMIN, F6_VMAX, F6_VAND, F6_VOR, F6_VXOR,
                              F6_VSLL, F6_VSRL, F6_VSRA, F6_VMERGE, F6_VMSEQ, F6_VMSNE,
                              F6_VMSLT, F6_VMSLE, F6_VMSGT};
    legal_o = vsew_i != SEW64 && (w_ls || w_red || w_sldu || w_alu);
    unit_o  = w_ls ? UNIT_LSU : w_red ? UNIT_RED : w_sldu ? UNIT_SLDU : UNIT_ALU;
  end
endmodule

// File: rtl/v_issue_seq.sv
// v_issue_seq: splits one vector instruction into byte-enabled DATA_W beats for its execution unit
module v_issue_seq
  import v_issue_seq_pkg::*;
#(
  parameter int VLEN_P   = VLEN,
  parameter int DATA_W_P = DATA_W,
  parameter int VL_W_P   = VL_W,
  parameter int BEAT_W_P = BEAT_W
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [31:0]             instr_i,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [31:0]             rs1_data_i,
  input  logic [VL_W_P-1:0]       vl_i,
  input  logic [1:0]              vsew_i,
  output logic                    uop_valid_o,
  input  logic                    uop_ready_i,
  output logic [1:0]              uop_unit_o,
  output logic [5:0]              uop_funct6_o,
  output logic [2:0]              uop_funct3_o,
  output logic [4:0]              uop_vd_o,
  output logic [4:0]              uop_vs1_o,
  output logic [4:0]              uop_vs2_o,
  output logic                    uop_vm_o,
  output logic [1:0]              uop_sew_o,
  output logic [31:0]             uop_scalar_o,
  output logic [BEAT_W_P-1:0]     uop_beat_o,
  output logic                    uop_first_o,
  output logic                    uop_last_o,
  output logic [DATA_W_P/8-1:0]   uop_byte_en_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    illegal_o
);
  localparam int BYTES = DATA_W_P / 8;
  localparam int VBYTES = VLEN_P / 8;
  localparam int TW = $clog2(VBYTES + 1);
  localparam int PW = VL_W_P + 3;
  state_e r_state, w_next;
  unit_e r_unit, w_unit;
  logic w_legal, w_accept, w_go, w_issue, w_last, w_fin, w_step;
  logic [PW-1:0] w_prod;
  logic [TW-1:0] w_total, r_rem;
  logic [31:0] w_scalar, r_scalar;
  logic [5:0] r_f6;
  logic [2:0] r_f3;
  logic [4:0] r_vd, r_vs1, r_vs2;
  logic [1:0] r_sew;
  logic [BEAT_W_P-1:0] r_beat;
  logic r_vm, r_done, r_illegal;
  v_issue_decode u_dec (
    .opcode_i (instr_i[6:0]),
    .funct3_i (instr_i[14:12]),
    .funct6_i (instr_i[31:26]),
    .vsew_i   (vsew_i),
    .legal_o  (w_legal),
    .unit_o   (w_unit)
  );
  // r_rem counts bytes still to issue, so the tail mask and last flag need no beat-count divide
  always_comb begin
    w_prod   = PW'(vl_i) * PW'(esz(vsew_i));
    w_total  = w_prod > PW'(VBYTES) ? TW'(VBYTES) : w_prod[TW-1:0];
    w_scalar = (instr_i[6:0] == OP_V && instr_i[14:12] == OPI_VI) ?
               {{27{instr_i[19]}}, instr_i[19:15]} : rs1_data_i;
    w_issue  = r_state == ISSUE;
    w_accept = instr_valid_i && !w_issue;
    w_go     = w_accept && w_legal && w_total != '0;
    w_last   = r_rem <= TW'(BYTES);
    w_fin    = w_issue && uop_ready_i && w_last;
    w_step   = w_issue && uop_ready_i && !w_last;
    w_next   = w_issue ? (w_fin ? IDLE : ISSUE) : (w_go ? ISSUE : IDLE);
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_unit    <= UNIT_ALU;
      r_f6      <= '0;
      r_f3      <= '0;
      r_vd      <= '0;
      r_vs1     <= '0;
      r_vs2     <= '0;
      r_vm      <= 1'b0;
      r_sew     <= '0;
      r_scalar  <= '0;
      r_beat    <= '0;
      r_rem     <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_done    <= (w_accept && w_legal && w_total == '0) || w_fin;
      r_illegal <= w_accept && !w_legal;
      if (w_go) begin
        r_unit   <= w_unit;
        r_f6     <= instr_i[31:26];
        r_f3     <= instr_i[14:12];
        r_vd     <= instr_i[11:7];
        r_vs1    <= instr_i[19:15];
        r_vs2    <= instr_i[24:20];
        r_vm     <= instr_i[25];
        r_sew    <= vsew_i;
        r_scalar <= w_scalar;
        r_beat   <= '0;
        r_rem    <= w_total;
      end else if (w_step) begin
        r_beat <= r_beat + BEAT_W_P'(1);
        r_rem  <= r_rem - TW'(BYTES);
      end
    end
  end
  assign instr_ready_o = !w_issue;
  assign busy_o        = w_issue;
  assign uop_valid_o   = w_issue;
  assign done_o        = r_done;
  assign illegal_o     = r_illegal;
  assign uop_unit_o    = r_unit;
  assign uop_funct6_o  = r_f6;
  assign uop_funct3_o  = r_f3;
  assign uop_vd_o      = r_vd;
  assign uop_vs1_o     = r_vs1;
  assign uop_vs2_o     = r_vs2;
  assign uop_vm_o      = r_vm;
  assign uop_sew_o     = r_sew;
  assign uop_scalar_o  = r_scalar;
  assign uop_beat_o    = r_beat;
  assign uop_first_o   = w_issue && r_beat == '0;
  assign uop_last_o    = w_issue && w_last;
  assign uop_byte_en_o = !w_issue ? '0 :
                         r_rem >= TW'(BYTES) ? '1 : ~({BYTES{1'b1}} << r_rem[$clog2(BYTES)-1:0]);
endmodule

// File: tb/tb_v_issue_seq.sv
// tb_v_issue_seq: directed scoreboard bench for the vector issue sequencer
module tb_v_issue_seq;
  import v_issue_seq_pkg::*;
  localparam logic [6:0] OPV = 7'b1010111;
  logic clk, nrst, instr_valid_i, instr_ready_o, uop_valid_o, uop_ready_i;
  logic [31:0] instr_i, rs1_data_i, uop_scalar_o;
  logic [6:0] vl_i;
  logic [1:0] vsew_i, uop_unit_o, uop_sew_o;
  logic [5:0] uop_funct6_o;
  logic [2:0] uop_funct3_o, uop_beat_o;
  logic [4:0] uop_vd_o, uop_vs1_o, uop_vs2_o;
  logic uop_vm_o, uop_first_o, uop_last_o, busy_o, done_o, illegal_o;
  logic [7:0] uop_byte_en_o;
  int vectors = 0, miscompares = 0;
  typedef struct {
    logic [1:0] unit; logic [2:0] beat; logic first; logic last;
    logic [7:0] be; logic [31:0] scalar; logic [1:0] sew;
  } exp_t;
  exp_t sb[$];

  v_issue_seq dut (
    .clk(clk), .nrst(nrst), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .rs1_data_i(rs1_data_i), .vl_i(vl_i), .vsew_i(vsew_i),
    .uop_valid_o(uop_valid_o), .uop_ready_i(uop_ready_i), .uop_unit_o(uop_unit_o),
    .uop_funct6_o(uop_funct6_o), .uop_funct3_o(uop_funct3_o), .uop_vd_o(uop_vd_o),
    .uop_vs1_o(uop_vs1_o), .uop_vs2_o(uop_vs2_o), .uop_vm_o(uop_vm_o), .uop_sew_o(uop_sew_o),
    .uop_scalar_o(uop_scalar_o), .uop_beat_o(uop_beat_o), .uop_first_o(uop_first_o),
    .uop_last_o(uop_last_o), .uop_byte_en_o(uop_byte_en_o), .busy_o(busy_o),
    .done_o(done_o), .illegal_o(illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] f6, input logic [4:0] vs2,
                                     input logic [4:0] vs1, input logic [2:0] f3,
                                     input logic [6:0] op);
    return {f6, 1'b1, vs2, vs1, f3, 5'd3, op};
  endfunction

  task automatic push(input logic [1:0] u, input int vl, input logic [1:0] sew,
                      input logic [31:0] sc);
    int total, nb, rem;
    exp_t e;
    total = vl * (1 << sew);
    if (total > 64) total = 64;
    nb = (total + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      rem = total - 8 * b;
      e.unit = u; e.beat = 3'(b); e.first = (b == 0); e.last = (b == nb - 1);
      e.be = rem >= 8 ? 8'hFF : 8'hFF >> (8 - rem);
      e.scalar = sc; e.sew = sew;
      sb.push_back(e);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] rs1, input int vl,
                      input logic [1:0] sew);
    check("ready_before_accept", {31'd0, instr_ready_o}, 1);
    instr_i = ins; rs1_data_i = rs1; vl_i = 7'(vl); vsew_i = sew; instr_valid_i = 1'b1;
    @(posedge clk); #1;
    instr_valid_i = 1'b0; instr_i = 32'hFFFF_FFFF; rs1_data_i = 32'hDEAD_BEEF; vl_i = 7'd1;
    vsew_i = 2'b11;
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    while (!done_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done_o}, 1);
    if (exp_n >= 0) check({tag, "_done_latency"}, n, exp_n);
    check({tag, "_ready_with_done"}, {31'd0, instr_ready_o}, 1);
    check({tag, "_busy_with_done"}, {31'd0, busy_o}, 0);
    check({tag, "_sb_drained"}, sb.size(), 0);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, {31'd0, done_o}, 0);
  endtask

  task automatic reject(input string tag, input logic [31:0] ins, input logic [1:0] sew);
    send(ins, 32'h1, 5, sew);
    check({tag, "_illegal"}, {31'd0, illegal_o}, 1);
    check({tag, "_no_uop"}, {31'd0, uop_valid_o}, 0);
    check({tag, "_ready"}, {31'd0, instr_ready_o}, 1);
    check({tag, "_no_done"}, {31'd0, done_o}, 0);
    @(posedge clk); #1;
    check({tag, "_illegal_pulse"}, {31'd0, illegal_o}, 0);
    check({tag, "_still_idle"}, {31'd0, uop_valid_o}, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (nrst && uop_valid_o && uop_ready_i) begin
      if (sb.size() == 0) check("uop_unexpected", {31'd0, uop_valid_o}, 0);
      else begin
        e = sb.pop_front();
        check("uop_unit", uop_unit_o, e.unit);
        check("uop_beat", uop_beat_o, e.beat);
        check("uop_first", {31'd0, uop_first_o}, {31'd0, e.first});
        check("uop_last", {31'd0, uop_last_o}, {31'd0, e.last});
        check("uop_byte_en", uop_byte_en_o, e.be);
        check("uop_scalar", uop_scalar_o, e.scalar);
        check("uop_sew", uop_sew_o, e.sew);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; instr_valid_i = 1'b0; uop_ready_i = 1'b1; instr_i = '0;
    rs1_data_i = '0; vl_i = '0; vsew_i = '0;
    #1;
    check("rst_ready", {31'd0, instr_ready_o}, 1);
    check("rst_valid", {31'd0, uop_valid_o}, 0);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    check("rst_illegal", {31'd0, illegal_o}, 0);
    check("rst_first", {31'd0, uop_first_o}, 0);
    check("rst_byte_en", uop_byte_en_o, 0);
    check("rst_scalar", uop_scalar_o, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;

    // vadd.vv, 20 bytes at SEW8: FF FF 0F
    push(2'd0, 20, 2'b00, 32'h0000_00A5);
    send(mk(6'b000000, 5'd2, 5'd1, 3'b000, OPV), 32'h0000_00A5, 20, 2'b00);
    check("vadd_valid_next_cycle", {31'd0, uop_valid_o}, 1);
    check("vadd_not_ready", {31'd0, instr_ready_o}, 0);
    check("vadd_funct6", uop_funct6_o, 0);
    check("vadd_vs2", uop_vs2_o, 2);
    check("vadd_vs1", uop_vs1_o, 1);
    check("vadd_vd", uop_vd_o, 3);
    wait_done("vadd", 3);

    // vredsum, ready withheld for four cycles on beat 0
    uop_ready_i = 1'b0;
    push(2'd1, 3, 2'b10, 32'h0000_1111);
    send(mk(6'b000000, 5'd4, 5'd5, 3'b010, OPV), 32'h0000_1111, 3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", {31'd0, uop_valid_o}, 1);
      check("hold_unit", uop_unit_o, 1);
      check("hold_beat", uop_beat_o, 0);
      check("hold_byte_en", uop_byte_en_o, 8'hFF);
      check("hold_first", {31'd0, uop_first_o}, 1);
      check("hold_last", {31'd0, uop_last_o}, 0);
      check("hold_funct3", uop_funct3_o, 3'b010);
      @(posedge clk); #1;
    end
    uop_ready_i = 1'b1;
    wait_done("vredsum", 2);

    // vslideup.vi with imm -2
    push(2'd2, 8, 2'b01, 32'hFFFF_FFFE);
    send(mk(6'b001110, 5'd4, 5'b11110, 3'b011, OPV), 32'h1234_5678, 8, 2'b01);
    wait_done("vslideup", 2);

    // vmerge.vx goes to ALU; 10 bytes -> FF 03
    push(2'd0, 5, 2'b01, 32'h0BAD_F00D);
    send(mk(6'b010111, 5'd6, 5'd7, 3'b100, OPV), 32'h0BAD_F00D, 5, 2'b01);
    wait_done("vmerge", 2);

    reject("opf_vv", mk(6'b000000, 5'd2, 5'd1, 3'b001, OPV), 2'b00);
    reject("sew64", mk(6'b000000, 5'd2, 5'd1, 3'b000, OPV), 2'b11);
    reject("system_op", mk(6'b000000, 5'd2, 5'd1, 3'b000, 7'b1110011), 2'b00);

    // vle with vl=0 completes without micro-ops
    send(mk(6'b000000, 5'd0, 5'd1, 3'b000, 7'b0000111), 32'h4000_0000, 0, 2'b00);
    check("vl0_done", {31'd0, done_o}, 1);
    check("vl0_no_uop", {31'd0, uop_valid_o}, 0);
    check("vl0_no_illegal", {31'd0, illegal_o}, 0);
    @(posedge clk); #1;
    check("vl0_done_pulse", {31'd0, done_o}, 0);

    push(2'd3, 64, 2'b00, 32'h8000_1000);
    send(mk(6'b000000, 5'd0, 5'd1, 3'b000, 7'b0000111), 32'h8000_1000, 64, 2'b00);
    wait_done("vle64", 8);

    // store with vl beyond VLMAX is clamped to 64 bytes
    push(2'd3, 100, 2'b10, 32'h0000_2000);
    send(mk(6'b000000, 5'd0, 5'd1, 3'b110, 7'b0100111), 32'h0000_2000, 100, 2'b10);
    wait_done("vse_clamp", 8);

    // reset during beat 1 abandons the instruction
    push(2'd0, 20, 2'b00, 32'h0000_0077);
    send(mk(6'b000000, 5'd2, 5'd1, 3'b000, OPV), 32'h0000_0077, 20, 2'b00);
    @(posedge clk); #1;
    check("rst_mid_beat1", uop_beat_o, 1);
    nrst = 1'b0;
    #1;
    sb.delete();
    check("rst_mid_valid", {31'd0, uop_valid_o}, 0);
    check("rst_mid_ready", {31'd0, instr_ready_o}, 1);
    check("rst_mid_busy", {31'd0, busy_o}, 0);
    check("rst_mid_byte_en", uop_byte_en_o, 0);
    check("rst_mid_scalar", uop_scalar_o, 0);
    check("rst_mid_beat", uop_beat_o, 0);
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_mid_no_done", {31'd0, done_o}, 0);
      check("rst_mid_idle_ready", {31'd0, instr_ready_o}, 1);
      check("rst_mid_idle_valid", {31'd0, uop_valid_o}, 0);
    end
    check("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
